// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port synchronous data RAM between the pipeline memory
//   stage (CPU port) and the DSP block-transfer engine (DSP port). The CPU
//   has priority, except that during a DSP burst at most MAX_CPU_RUN
//   consecutive CPU grants are allowed before one DSP beat is forced in.
//   DSP bursts are 1..16 words with an auto-incrementing, wrapping address.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata   CPU request (rd and wr never together)
//   cpu_stall                  CPU request not granted this cycle
//   cpu_rdata                  CPU read data, valid the cycle after a granted read
//   dsp_start/dsp_we/dsp_base/dsp_len  burst start pulse and burst descriptor
//   dsp_wdata                  write data for the current beat
//   dsp_beat                   DSP beat granted this cycle
//   dsp_rdata/dsp_rvalid       burst read data and its valid strobe
//   dsp_busy/dsp_done          burst in progress / completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port (1-cycle read latency)

module data_mem_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dsp_start,
  input  logic              dsp_we,
  input  logic [ADDR_W-1:0] dsp_base,
  input  logic [4:0]        dsp_len,
  input  logic [DATA_W-1:0] dsp_wdata,
  output logic              dsp_beat,
  output logic [DATA_W-1:0] dsp_rdata,
  output logic              dsp_rvalid,
  output logic              dsp_busy,
  output logic              dsp_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int RUN_W = ($clog2(MAX_CPU_RUN + 1) > 3) ? $clog2(MAX_CPU_RUN + 1) : 3;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DSP
  } owner_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cur_addr, cur_addr_next;
  logic [4:0]        beats_left, beats_left_next;
  logic [RUN_W-1:0]  cpu_run, cpu_run_next;
  logic              burst_we, burst_we_next;
  owner_t            rd_owner;
  logic              done_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dsp_rdata_q;

  logic cpu_req;
  logic cpu_grant;
  logic dsp_grant;
  logic last_beat;

  assign cpu_req = cpu_rd | cpu_wr;

  // Next-state and grant decision. While reset is high nothing is granted so
  // a burst caught mid-flight cannot issue a stray RAM write.
  always_comb begin
    state_next      = state;
    cur_addr_next   = cur_addr;
    beats_left_next = beats_left;
    cpu_run_next    = cpu_run;
    burst_we_next   = burst_we;
    cpu_grant       = 1'b0;
    dsp_grant       = 1'b0;
    last_beat       = 1'b0;

    if (!reset) begin
      case (state)
        IDLE: begin
          cpu_grant    = cpu_req;
          cpu_run_next = '0;
          if (dsp_start && (dsp_len != '0)) begin
            cur_addr_next   = dsp_base;
            beats_left_next = dsp_len;
            burst_we_next   = dsp_we;
            state_next      = BURST;
          end
        end
        BURST: begin
          if (cpu_req && (cpu_run < RUN_MAX)) begin
            cpu_grant    = 1'b1;
            cpu_run_next = cpu_run + 1'b1;
          end else begin
            dsp_grant       = 1'b1;
            cpu_run_next    = '0;
            cur_addr_next   = cur_addr + 1'b1;
            beats_left_next = beats_left - 1'b1;
            if (beats_left <= 5'd1) begin
              last_beat  = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // RAM port steering and handshake outputs.
  always_comb begin
    mem_en    = cpu_grant | dsp_grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dsp_grant) begin
      mem_we    = burst_we;
      mem_addr  = cur_addr;
      mem_wdata = dsp_wdata;
    end else if (cpu_grant) begin
      mem_we    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    cpu_stall = cpu_req & ~cpu_grant & ~reset;
    dsp_beat  = dsp_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      cpu_run     <= '0;
      burst_we    <= 1'b0;
      rd_owner    <= OWN_NONE;
      done_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dsp_rdata_q <= '0;
    end else begin
      state      <= state_next;
      cur_addr   <= cur_addr_next;
      beats_left <= beats_left_next;
      cpu_run    <= cpu_run_next;
      burst_we   <= burst_we_next;
      done_q     <= last_beat;
      if (cpu_grant && cpu_rd) begin
        rd_owner <= OWN_CPU;
      end else if (dsp_grant && !burst_we) begin
        rd_owner <= OWN_DSP;
      end else begin
        rd_owner <= OWN_NONE;
      end
      if (rd_owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (rd_owner == OWN_DSP) dsp_rdata_q <= mem_rdata;
    end
  end

  // RAM data is passed straight through in the return cycle and then held,
  // so each port keeps its last read word while the other port uses the RAM.
  assign cpu_rdata  = (rd_owner == OWN_CPU) ? mem_rdata : cpu_rdata_q;
  assign dsp_rdata  = (rd_owner == OWN_DSP) ? mem_rdata : dsp_rdata_q;
  assign dsp_rvalid = (rd_owner == OWN_DSP);
  assign dsp_busy   = (state == BURST);
  assign dsp_done   = done_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Cycle table of {inputs, expected combinational outputs} applied to
//   data_mem_arbiter with a behavioural single-port RAM behind it. Read
//   results are predicted from a shadow copy of what the table writes and
//   queued with their due cycle; they are popped when the DUT returns data.

module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dsp_start, dsp_we;
  logic [11:0] dsp_base;
  logic [4:0]  dsp_len;
  logic [31:0] dsp_wdata;
  logic        dsp_beat;
  logic [31:0] dsp_rdata;
  logic        dsp_rvalid, dsp_busy, dsp_done;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_CPU_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dsp_start(dsp_start), .dsp_we(dsp_we), .dsp_base(dsp_base), .dsp_len(dsp_len),
    .dsp_wdata(dsp_wdata), .dsp_beat(dsp_beat), .dsp_rdata(dsp_rdata),
    .dsp_rvalid(dsp_rvalid), .dsp_busy(dsp_busy), .dsp_done(dsp_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        rst, crd, cwr;
    logic [11:0] caddr;
    logic [31:0] cwd;
    logic        st, dwe;
    logic [11:0] base;
    logic [4:0]  len;
    logic [31:0] dwd;
    logic        e_stall, e_beat, e_en, e_we;
    logic [11:0] e_addr;
    logic        e_busy, e_done;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  vec_t        vecs[$];
  sb_t         cpu_q[$];
  sb_t         dsp_q[$];
  logic [31:0] shadow [0:4095];
  int checks = 0;
  int failures = 0;
  int row = 0;
  int cyc = 0;

  function automatic vec_t mk(int rst, int crd, int cwr, int caddr, int cwd,
                              int st, int dwe, int base, int len, int dwd,
                              int e_stall, int e_beat, int e_en, int e_we,
                              int e_addr, int e_busy, int e_done);
    vec_t v;
    v.rst = 1'(rst); v.crd = 1'(crd); v.cwr = 1'(cwr);
    v.caddr = 12'(caddr); v.cwd = 32'(cwd);
    v.st = 1'(st); v.dwe = 1'(dwe); v.base = 12'(base); v.len = 5'(len);
    v.dwd = 32'(dwd);
    v.e_stall = 1'(e_stall); v.e_beat = 1'(e_beat); v.e_en = 1'(e_en);
    v.e_we = 1'(e_we); v.e_addr = 12'(e_addr);
    v.e_busy = 1'(e_busy); v.e_done = 1'(e_done);
    return v;
  endfunction

  // Granted CPU access with no DSP activity on the inputs.
  function automatic vec_t cpu(int rd, int wr, int addr, int wd, int busy);
    return mk(0, rd, wr, addr, wd, 0, 0, 0, 0, 0, 0, 0, 1, wr, addr, busy, 0);
  endfunction

  function automatic vec_t idle(int busy, int done);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy, done);
  endfunction

  function automatic vec_t start(int we, int base, int len);
    return mk(0, 0, 0, 0, 0, 1, we, base, len, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t beat(int we, int addr, int dwd);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, dwd, 0, 1, 1, we, addr, 1, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  int          ra [7] = '{12'h020, 12'h021, 12'h022, 12'h023, 12'hFFE, 12'hFFF, 12'h000};
  logic [31:0] rv [7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hA, 32'hB, 32'hC};

  initial begin
    vec_t v;
    sb_t  e;
    int   addrs [3] = '{8, 9, 10};
    int   p;

    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dsp_start = 1'b0; dsp_we = 1'b0; dsp_base = '0; dsp_len = '0; dsp_wdata = '0;
    repeat (2) @(posedge clk);
    #5;
    chk("rst_cpu_stall", 32'(cpu_stall), 0);
    chk("rst_dsp_beat", 32'(dsp_beat), 0);
    chk("rst_dsp_rvalid", 32'(dsp_rvalid), 0);
    chk("rst_dsp_busy", 32'(dsp_busy), 0);
    chk("rst_dsp_done", 32'(dsp_done), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dsp_rdata", dsp_rdata, 0);

    // CPU only: writes then read-back.
    vecs.push_back(cpu(0, 1, 8, 37, 0));
    vecs.push_back(cpu(0, 1, 9, 39, 0));
    vecs.push_back(cpu(0, 1, 10, 43, 0));
    vecs.push_back(cpu(0, 1, 57, 32'h5757, 0));
    vecs.push_back(cpu(1, 0, 8, 0, 0));
    vecs.push_back(cpu(1, 0, 9, 0, 0));
    vecs.push_back(cpu(1, 0, 10, 0, 0));
    vecs.push_back(idle(0, 0));

    // Idle DSP write burst 0x020, len 4, data 1..4.
    vecs.push_back(start(1, 12'h020, 4));
    for (int i = 0; i < 4; i++) vecs.push_back(beat(1, 12'h020 + i, i + 1));
    vecs.push_back(idle(0, 1));
    vecs.push_back(idle(0, 0));

    // DSP read of the same words under continuous CPU reads; start coincides
    // with a CPU read in IDLE, so the CPU wins that cycle.
    vecs.push_back(mk(0, 1, 0, 8, 0, 1, 0, 12'h020, 4, 0, 0, 0, 1, 0, 8, 0, 0));
    p = 1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        vecs.push_back(cpu(1, 0, addrs[p % 3], 0, 1));
        p++;
      end
      vecs.push_back(mk(0, 1, 0, addrs[p % 3], 0, 0, 0, 0, 0, 0,
                        1, 1, 1, 0, 12'h020 + b, 1, 0));
    end
    vecs.push_back(mk(0, 1, 0, addrs[p % 3], 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, addrs[p % 3], 0, 1));
    vecs.push_back(idle(0, 0));

    // Address wrap 0xFFE -> 0x000, then CPU read-back.
    vecs.push_back(start(1, 12'hFFE, 3));
    vecs.push_back(beat(1, 12'hFFE, 32'hA));
    vecs.push_back(beat(1, 12'hFFF, 32'hB));
    vecs.push_back(beat(1, 12'h000, 32'hC));
    vecs.push_back(idle(0, 1));
    vecs.push_back(cpu(1, 0, 12'hFFE, 0, 0));
    vecs.push_back(cpu(1, 0, 12'hFFF, 0, 0));
    vecs.push_back(cpu(1, 0, 12'h000, 0, 0));
    vecs.push_back(idle(0, 0));

    // Ignored starts: zero length, and a second start mid-burst.
    vecs.push_back(start(1, 12'h100, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(start(1, 12'h040, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 12'h080, 5, 5, 0, 1, 1, 1, 12'h040, 1, 0));
    vecs.push_back(beat(1, 12'h041, 6));
    vecs.push_back(idle(0, 1));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));

    // Reset in the middle of a len-8 read burst with a CPU read waiting.
    vecs.push_back(start(0, 12'h020, 8));
    vecs.push_back(beat(0, 12'h020, 0));
    vecs.push_back(beat(0, 12'h021, 0));
    vecs.push_back(mk(1, 1, 0, 57, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(cpu(1, 0, 57, 0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));

    foreach (vecs[i]) begin
      v = vecs[i];
      row = i;
      @(posedge clk);
      #1;
      reset = v.rst; cpu_rd = v.crd; cpu_wr = v.cwr; cpu_addr = v.caddr; cpu_wdata = v.cwd;
      dsp_start = v.st; dsp_we = v.dwe; dsp_base = v.base; dsp_len = v.len; dsp_wdata = v.dwd;
      #4;
      chk("cpu_stall", 32'(cpu_stall), 32'(v.e_stall));
      chk("dsp_beat", 32'(dsp_beat), 32'(v.e_beat));
      chk("mem_en", 32'(mem_en), 32'(v.e_en));
      chk("dsp_busy", 32'(dsp_busy), 32'(v.e_busy));
      chk("dsp_done", 32'(dsp_done), 32'(v.e_done));
      if (v.e_en) begin
        chk("mem_we", 32'(mem_we), 32'(v.e_we));
        chk("mem_addr", 32'(mem_addr), 32'(v.e_addr));
        if (v.e_we) chk("mem_wdata", mem_wdata, v.e_beat ? v.dwd : v.cwd);
      end

      if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
        e = cpu_q.pop_front();
        chk("cpu_rdata", cpu_rdata, e.data);
      end
      if (dsp_rvalid) begin
        if (dsp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dsp_rvalid_unexpected row=%0d actual=1 expected=0", row);
        end else begin
          e = dsp_q.pop_front();
          chk("dsp_rdata", dsp_rdata, e.data);
          chk("dsp_rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (dsp_q.size() > 0 && dsp_q[0].due <= cyc) begin
        e = dsp_q.pop_front();
        checks++; failures++;
        $display("FAIL dsp_rvalid_missing row=%0d actual=0 expected=1 data=%0h", row, e.data);
      end

      if (v.e_en) begin
        if (v.e_we) begin
          shadow[v.e_addr] = v.e_beat ? v.dwd : v.cwd;
        end else if (v.e_beat) begin
          dsp_q.push_back('{data: shadow[v.e_addr], due: cyc + 1});
        end else begin
          cpu_q.push_back('{data: shadow[v.e_addr], due: cyc + 1});
        end
      end
      cyc++;
    end

    while (cpu_q.size() > 0) begin
      e = cpu_q.pop_front();
      checks++; failures++;
      $display("FAIL cpu_rdata_never_checked actual=none expected=%0h", e.data);
    end
    while (dsp_q.size() > 0) begin
      e = dsp_q.pop_front();
      checks++; failures++;
      $display("FAIL dsp_rvalid_never_seen actual=none expected=%0h", e.data);
    end

    for (int i = 0; i < 7; i++) chk("ram_content", ram[ra[i]], rv[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port synchronous data memory between the pipeline's memory stage (CPU port) and the DSP peripheral block-transfer engine (DSP port). The CPU normally has priority. A fairness counter guarantees the DSP one beat after a bounded run of CPU accesses. DSP transfers are bursts of 1–16 words with an auto-incrementing address. The block sits between the memory stage and the data RAM and drives the RAM's only port.

## Interface
- ADDR_W, 12, data memory word-address width
- DATA_W, 32, data word width
- MAX_CPU_RUN, 4, consecutive CPU grants allowed while a DSP beat is pending (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cpu_rd  in  1  memory-stage read request (Memory_Read)
- cpu_wr  in  1  memory-stage write request (Memory_Write); never asserted together with cpu_rd
- cpu_addr  in  ADDR_W  CPU word address (low bits of ALU Result)
- cpu_wdata  in  DATA_W  CPU write data (data1)
- cpu_stall  out  1  CPU request not granted this cycle; pipeline holds
- cpu_rdata  out  DATA_W  read data, valid the cycle after a granted cpu_rd
- dsp_start  in  1  one-cycle burst start pulse
- dsp_we  in  1  burst direction (1 = write), sampled with dsp_start
- dsp_base  in  ADDR_W  burst start address, sampled with dsp_start
- dsp_len  in  5  burst length, 1..16, sampled with dsp_start
- dsp_wdata  in  DATA_W  write data for the current beat
- dsp_beat  out  1  DSP beat granted this cycle; the DSP advances its write data on this pulse
- dsp_rdata  out  DATA_W  burst read data
- dsp_rvalid  out  1  dsp_rdata valid (read bursts only)
- dsp_busy  out  1  burst in progress
- dsp_done  out  1  one-cycle pulse at burst completion
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency

## Operation
- State machine: IDLE, BURST. Registers: state, cur_addr, beats_left (5 b), cpu_run (3 b min), rd_owner (1-cycle delayed grant tag).
- IDLE:
  - CPU request granted every cycle; cpu_stall = 0.
  - dsp_start captures dsp_base into cur_addr and dsp_len into beats_left, latches dsp_we, then moves to BURST.
  - dsp_start with dsp_len = 0 is ignored: no busy, no done.
- BURST, arbitration decided each cycle:
  - CPU request and cpu_run < MAX_CPU_RUN: grant CPU, cpu_run += 1, cpu_stall = 0.
  - Otherwise, grant a DSP beat and clear cpu_run to 0. A pending CPU request sees cpu_stall = 1 that cycle.
- DSP beat:
  - mem_addr = cur_addr, mem_we = latched dsp_we, mem_wdata = dsp_wdata, dsp_beat = 1.
  - cur_addr += 1, wrapping 0xFFF → 0x000. beats_left −= 1.
  - On the last beat, return to IDLE.
- CPU grant: mem_addr = cpu_addr, mem_we = cpu_wr, mem_wdata = cpu_wdata.
- mem_en = 1 on any grant; 0 when there is no request.
- dsp_start while dsp_busy is ignored.
- Read return: rd_owner routes mem_rdata. A CPU grant sets cpu_rdata; a DSP read beat sets dsp_rdata and dsp_rvalid.
- Reset (including mid-burst): state IDLE, all counters 0, no dsp_done, no dsp_rvalid. Any stalled CPU request is served the next cycle.

## Timing
- Reset values: cpu_stall 0, dsp_beat 0, dsp_rvalid 0, dsp_busy 0, dsp_done 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, dsp_rdata 0.
- Grant, cpu_stall, dsp_beat and mem_* are combinational from state and requests in the same cycle.
- dsp_busy is registered. It rises the cycle after dsp_start and falls the cycle after the last beat.
- dsp_done pulses the cycle after the last beat. On read bursts it coincides with the final dsp_rvalid.
- Read latency is 1 cycle for both ports. dsp_rvalid is registered.
- Under continuous CPU load, the DSP receives ≥1 beat per MAX_CPU_RUN+1 cycles. Burst of L words completes in ≤ L·(MAX_CPU_RUN+1) cycles.
- dsp_start together with a CPU request in IDLE: CPU is granted, and the burst starts next cycle.

## Test plan
- CPU only: write 37, 39, 43 to addresses 8, 9, 10, then read them back → cpu_stall stays 0; cpu_rdata = 37, 39, 43, each one cycle after its read.
- Idle DSP write burst: base 0x020, len 4, data 1..4, no CPU traffic → dsp_beat for 4 consecutive cycles; RAM holds 1..4 at 0x020–0x023; dsp_done in cycle 5.
- DSP read of the same words with CPU reads on every cycle, MAX_CPU_RUN = 4 → pattern of 4 CPU grants then 1 DSP beat with cpu_stall = 1 in that cycle; dsp_rvalid returns 1..4 in order; dsp_done with the last one.
- Wrap-around: base 0xFFE, len 3, write → words land at 0xFFE, 0xFFF, 0x000.
- Ignored starts: dsp_start with len 0 → no busy, no done. Second dsp_start mid-burst → first burst is unaffected, no extra done.
- Reset in the middle of a len-8 read burst → next cycle busy 0, no done, no rvalid; a following CPU read at address 57 completes without stall.
